// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one uart_transmitter between NUM_REQ byte
// producers and spaces loads so each frame and its stop gap finish first.
module uart_tx_scheduler #(
  parameter int NUM_REQ      = 4,
  parameter int IDX_W        = 2,
  parameter int FRAME_CYCLES = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [8*NUM_REQ-1:0] req_data_i,
  output logic [NUM_REQ-1:0]   ack_o,
  output logic [7:0]           tx_data_o,
  output logic                 tx_load_o,
  output logic                 busy_o,
  output logic [IDX_W-1:0]     owner_o
);

  localparam int CNT_W = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   last_q;
  logic [IDX_W-1:0]   owner_q;
  logic [7:0]         tx_data_q;
  logic [NUM_REQ-1:0] ack_q;
  logic               tx_load_q;
  logic               busy_q;

  logic [IDX_W-1:0]   win_d;
  logic [NUM_REQ-1:0] grant_oh_d;
  logic               found_d;

  // Search starts one past the previous winner, so the last owner ranks lowest.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    win_d   = last_q;
    found_d = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found_d && req_i[(int'(last_q) + i) % NUM_REQ]) begin
        found_d = 1'b1;
        win_d   = IDX_W'((int'(last_q) + i) % NUM_REQ);
      end
    end
    grant_oh_d = NUM_REQ'(1) << win_d;
  end

  // NOTE: state uses non-blocking assignments only; ack/tx_load default low so
  // they are single-cycle pulses emitted while the FSM sits in LOAD.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      owner_q   <= '0;
      tx_data_q <= 8'h00;
      ack_q     <= '0;
      tx_load_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ack_q     <= '0;
      tx_load_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (en_i && found_d) begin
            tx_data_q <= req_data_i[8*win_d +: 8];
            owner_q   <= win_d;
            last_q    <= win_d;
            ack_q     <= grant_oh_d;
            tx_load_q <= 1'b1;
            busy_q    <= 1'b1;
            state_q   <= LOAD;
          end
        end
        LOAD: begin
          cnt_q   <= CNT_W'(FRAME_CYCLES - 1);
          state_q <= WAIT;
        end
        WAIT: begin
          if (cnt_q == CNT_W'(1)) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ack_o     = ack_q;
  assign tx_data_o = tx_data_q;
  assign tx_load_o = tx_load_q;
  assign busy_o    = busy_q;
  assign owner_o   = owner_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler: expected grants are queued as stimulus
// is driven and compared by a monitor whenever the DUT pulses tx_load.
module tb_uart_tx_scheduler;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef struct packed {
    logic [IDX_W-1:0] owner;
    logic [7:0]       data;
  } grant_t;

  logic                 clk = 1'b0;
  logic                 rst_i;
  logic                 en_i;
  logic [NUM_REQ-1:0]   req_i;
  logic [8*NUM_REQ-1:0] req_data_i;
  logic [NUM_REQ-1:0]   ack_o;
  logic [7:0]           tx_data_o;
  logic                 tx_load_o;
  logic                 busy_o;
  logic [IDX_W-1:0]     owner_o;

  grant_t sb_q[$];
  int     tests_run = 0;
  int     fails     = 0;
  int     cyc       = 0;

  uart_tx_scheduler #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .FRAME_CYCLES(10)) dut (
    .clk_i      (clk),
    .rst_i      (rst_i),
    .en_i       (en_i),
    .req_i      (req_i),
    .req_data_i (req_data_i),
    .ack_o      (ack_o),
    .tx_data_o  (tx_data_o),
    .tx_load_o  (tx_load_o),
    .busy_o     (busy_o),
    .owner_o    (owner_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx);
    grant_t g;
    g.owner = IDX_W'(idx);
    g.data  = req_data_i[8*idx +: 8];
    sb_q.push_back(g);
  endtask

  task automatic wait_load(input string tag, output int at_cyc);
    int n;
    n = 0;
    tick();
    while (!tx_load_o && n < 40) begin
      tick();
      n++;
    end
    check(tag, {31'd0, tx_load_o}, 32'd1);
    at_cyc = cyc;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy_o && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy_o}, 32'd0);
  endtask

  // Scoreboard monitor: every load must match the oldest queued grant.
  always @(negedge clk) begin
    if (!rst_i && tx_load_o) begin
      check("load_expected", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        grant_t g;
        g = sb_q.pop_front();
        check("sb_owner", {30'd0, owner_o}, {30'd0, g.owner});
        check("sb_data", {24'd0, tx_data_o}, {24'd0, g.data});
        check("sb_ack", {28'd0, ack_o}, 32'd1 << g.owner);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_prev, t_now, nb, loads;

    rst_i = 1'b1; en_i = 1'b1; req_i = '0; req_data_i = '0;
    tick(); tick();
    rst_i = 1'b0;
    check("rst_busy", {31'd0, busy_o}, 32'd0);
    check("rst_ack", {28'd0, ack_o}, 32'd0);
    check("rst_load", {31'd0, tx_load_o}, 32'd0);
    check("rst_data", {24'd0, tx_data_o}, 32'd0);
    check("rst_owner", {30'd0, owner_o}, 32'd0);

    // 1: single requester, one-cycle latency, busy for 10 cycles
    req_data_i = 32'h0000_0055;
    req_i = 4'b0001;
    push(0);
    tick();
    check("t1_load", {31'd0, tx_load_o}, 32'd1);
    check("t1_ack", {28'd0, ack_o}, 32'd1);
    check("t1_data", {24'd0, tx_data_o}, 32'h55);
    req_i = '0;
    nb = 1;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy_o) nb++;
    end
    check("t1_busy_len", nb, 10);
    check("t1_data_hold", {24'd0, tx_data_o}, 32'h55);

    // 2: all requesting after reset -> 0,1,2,3,0 every 11 cycles
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    req_data_i = 32'hA3A2_A1A0;
    req_i = 4'b1111;
    push(0); push(1); push(2); push(3); push(0);
    wait_load("t2_load0", t_prev);
    for (int k = 1; k < 5; k++) begin
      wait_load("t2_load", t_now);
      check("t2_spacing", t_now - t_prev, 11);
      t_prev = t_now;
    end
    req_i = '0;
    wait_idle();

    // 3: grant 1, then 1010 held -> 3,1,3
    req_i = 4'b0010;
    push(1);
    wait_load("t3_load1", t_prev);
    req_i = 4'b1010;
    push(3); push(1); push(3);
    for (int k = 0; k < 3; k++) wait_load("t3_load", t_now);
    req_i = '0;
    wait_idle();

    // 4: en gating
    en_i = 1'b0;
    req_i = 4'b0100;
    loads = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      if (tx_load_o) loads++;
    end
    check("t4_no_load", loads, 0);
    check("t4_idle", {31'd0, busy_o}, 32'd0);
    en_i = 1'b1;
    push(2);
    tick();
    check("t4_load_en", {31'd0, tx_load_o}, 32'd1);
    req_i = 4'b0001;
    nb = 1; loads = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 2) en_i = 1'b0;
      if (busy_o) nb++;
      if (tx_load_o) loads++;
    end
    check("t4_busy_len", nb, 10);
    check("t4_hold_load", loads, 0);
    en_i = 1'b1;
    push(0);
    tick();
    check("t4_load_en2", {31'd0, tx_load_o}, 32'd1);
    req_i = '0;
    wait_idle();

    // 5: reset in WAIT cycle 4 aborts, then RR pointer back to 0 first
    req_i = 4'b0010;
    push(1);
    wait_load("t5_load", t_now);
    req_i = '0;
    for (int i = 0; i < 4; i++) tick();
    check("t5_busy_pre", {31'd0, busy_o}, 32'd1);
    rst_i = 1'b1;
    tick();
    check("t5_busy", {31'd0, busy_o}, 32'd0);
    check("t5_ack", {28'd0, ack_o}, 32'd0);
    check("t5_load0", {31'd0, tx_load_o}, 32'd0);
    check("t5_owner", {30'd0, owner_o}, 32'd0);
    rst_i = 1'b0;
    req_i = 4'b1001;
    push(0);
    wait_load("t5_load_after", t_now);
    check("t5_first_owner", {30'd0, owner_o}, 32'd0);
    req_i = '0;
    wait_idle();

    check("sb_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
